pong_score_keeper: RTL and testbench

Parametrised match scorer for the Pong datapath. Counts goals for `NUM_PLAYERS` players from the ball/collision logic and detects the winner. Runs the match state machine (idle, play, serve hold, game over) that gates the ball serve. All logic is synchronous to the pixel clock, so goal strobes are never used as clocks.

---
 rtl/pong_score_keeper.sv | 189 ++++++++++++++++++
 tb/tb_pong_score_keeper.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : pong_score_keeper
//  Description : Match scorer for the Pong datapath. Edge-detects goal
//                levels, keeps saturating per-player scores, runs the
//                IDLE/PLAY/HOLD/OVER match FSM and reports the winner.
//                Optional build macro: SCORE_WIN_BY_TWO_EN (win needs a
//                lead of two; a saturated score ends the match).
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_score_keeper #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                                                 i_clk,
    input  logic                                                 i_rst_n,
    input  logic                                                 i_start,
    input  logic [NUM_PLAYERS-1:0]                               i_goal,
    output logic [NUM_PLAYERS*SCORE_W-1:0]                       o_score,
    output logic [1:0]                                           o_state,
    output logic                                                 o_serve_hold,
    output logic [((NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1)-1:0] o_last_scorer,
    output logic                                                 o_game_over,
    output logic [((NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1)-1:0] o_winner
);

    localparam int c_IDX_W  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_PLAY = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;
    localparam logic [1:0] c_ST_OVER = 2'd3;

    localparam logic [SCORE_W-1:0]  c_SAT       = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0]  c_WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_CYCLES - 1);
`ifdef SCORE_WIN_BY_TWO_EN
    localparam logic [SCORE_W:0]    c_TWO       = (SCORE_W+1)'(2);
`endif

    logic [1:0]             r_state;
    logic [SCORE_W-1:0]     r_score [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] r_goal_q;
    logic [c_IDX_W-1:0]     r_last;
    logic [c_IDX_W-1:0]     r_winner;
    logic [c_HOLD_W-1:0]    r_hold_cnt;

    logic [1:0]             w_state_nx;
    logic [SCORE_W-1:0]     w_score_nx [NUM_PLAYERS];
    logic [SCORE_W-1:0]     w_credit   [NUM_PLAYERS];
    logic [c_IDX_W-1:0]     w_last_nx;
    logic [c_IDX_W-1:0]     w_winner_nx;
    logic [c_HOLD_W-1:0]    w_hold_nx;
    logic [NUM_PLAYERS-1:0] w_rise;
    logic [c_IDX_W-1:0]     w_first;
    logic                   w_won;
    logic [c_IDX_W-1:0]     w_win_idx;
`ifdef SCORE_WIN_BY_TWO_EN
    logic                   w_any_sat;
    logic                   w_lead_ok;
    logic [SCORE_W-1:0]     w_best_val;
`endif

    // Credit computation, win check and match FSM next-state logic
    always_comb begin
        w_rise      = i_goal & ~r_goal_q;
        w_state_nx  = r_state;
        w_last_nx   = r_last;
        w_winner_nx = r_winner;
        w_hold_nx   = r_hold_cnt;
        w_first     = '0;
        w_won       = 1'b0;
        w_win_idx   = '0;
`ifdef SCORE_WIN_BY_TWO_EN
        w_any_sat   = 1'b0;
        w_lead_ok   = 1'b0;
        w_best_val  = '0;
`endif
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            w_score_nx[k] = r_score[k];
            w_credit[k]   = (w_rise[k] && (r_score[k] != c_SAT)) ? r_score[k] + 1'b1 : r_score[k];
        end

        // Scan downward so the lowest index is the one left standing
        for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
            if (w_rise[k]) w_first = c_IDX_W'(k);
        end

`ifdef SCORE_WIN_BY_TWO_EN
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            if (w_credit[k] == c_SAT) w_any_sat = 1'b1;
        end
        if (w_any_sat) begin
            // A saturated score cannot grow, so the match must end here
            w_won      = 1'b1;
            w_best_val = w_credit[0];
            for (int k = 1; k < NUM_PLAYERS; k++) begin
                if (w_credit[k] > w_best_val) begin
                    w_best_val = w_credit[k];
                    w_win_idx  = c_IDX_W'(k);
                end
            end
        end else begin
            for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
                w_lead_ok = 1'b1;
                for (int j = 0; j < NUM_PLAYERS; j++) begin
                    if ((j != k) && ({1'b0, w_credit[k]} < ({1'b0, w_credit[j]} + c_TWO)))
                        w_lead_ok = 1'b0;
                end
                if ((w_credit[k] >= c_WIN) && w_lead_ok) begin
                    w_won     = 1'b1;
                    w_win_idx = c_IDX_W'(k);
                end
            end
        end
`else
        for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
            if (w_credit[k] >= c_WIN) begin
                w_won     = 1'b1;
                w_win_idx = c_IDX_W'(k);
            end
        end
`endif

        if (i_start) begin
            // Start/restart beats any goal arriving in the same clock
            w_state_nx = c_ST_PLAY;
            for (int k = 0; k < NUM_PLAYERS; k++) w_score_nx[k] = '0;
        end else begin
            case (r_state)
                c_ST_PLAY: begin
                    if (|w_rise) begin
                        for (int k = 0; k < NUM_PLAYERS; k++) w_score_nx[k] = w_credit[k];
                        w_last_nx = w_first;
                        if (w_won) begin
                            w_state_nx  = c_ST_OVER;
                            w_winner_nx = w_win_idx;
                        end else begin
                            w_state_nx = c_ST_HOLD;
                            w_hold_nx  = c_HOLD_LOAD;
                        end
                    end
                end
                c_ST_HOLD: begin
                    if (r_hold_cnt == '0) w_state_nx = c_ST_PLAY;
                    else                  w_hold_nx  = r_hold_cnt - 1'b1;
                end
                default: begin
                    // IDLE and OVER hold everything until a start
                end
            endcase
        end
    end

    // State and score registers; goal history tracks the input even in reset
    always_ff @(posedge i_clk) begin
        r_goal_q <= i_goal;
        if (!i_rst_n) begin
            r_state    <= c_ST_IDLE;
            r_last     <= '0;
            r_winner   <= '0;
            r_hold_cnt <= '0;
            for (int k = 0; k < NUM_PLAYERS; k++) r_score[k] <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_last     <= w_last_nx;
            r_winner   <= w_winner_nx;
            r_hold_cnt <= w_hold_nx;
            for (int k = 0; k < NUM_PLAYERS; k++) r_score[k] <= w_score_nx[k];
        end
    end

    generate
        for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
            assign o_score[g*SCORE_W +: SCORE_W] = r_score[g];
        end
    endgenerate

    assign o_state       = r_state;
    assign o_serve_hold  = (r_state == c_ST_HOLD);
    assign o_game_over   = (r_state == c_ST_OVER);
    assign o_last_scorer = r_last;
    assign o_winner      = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_pong_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pong_score_keeper
//  Description : Self-checking bench for pong_score_keeper (2 players,
//                4-bit scores, win at 7, 16-clock serve hold). A reference
//                model pushes expected outputs per clock; they are popped
//                and compared after the edge. Honours SCORE_WIN_BY_TWO_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_score_keeper;

    localparam int c_HOLD = 16;

    typedef struct {
        int s0;
        int s1;
        int st;
        int hold;
        int last;
        int go;
        int win;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] goal;
    logic [7:0] score;
    logic [1:0] state;
    logic       serve_hold;
    logic [0:0] last_scorer;
    logic       game_over;
    logic [0:0] winner;

    exp_t q_exp[$];
    int   n_vec;
    int   n_err;
    int   hold_seen;

    // Reference model state
    int         m_st;
    int         m_s0;
    int         m_s1;
    int         m_last;
    int         m_win;
    int         m_left;
    logic [1:0] m_goal_q;

    pong_score_keeper #(
        .NUM_PLAYERS(2),
        .SCORE_W    (4),
        .WIN_SCORE  (7),
        .HOLD_CYCLES(c_HOLD)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_goal       (goal),
        .o_score      (score),
        .o_state      (state),
        .o_serve_hold (serve_hold),
        .o_last_scorer(last_scorer),
        .o_game_over  (game_over),
        .o_winner     (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Model one rising edge with the inputs being driven
    task automatic model_step(input logic r, input logic s, input logic [1:0] g);
        logic [1:0] rise;
        if (!r) begin
            m_st = 0; m_s0 = 0; m_s1 = 0; m_last = 0; m_win = 0; m_left = 0;
            m_goal_q = g;
            return;
        end
        rise = g & ~m_goal_q;
        m_goal_q = g;
        if (s) begin
            m_st = 1; m_s0 = 0; m_s1 = 0;
        end else if (m_st == 1 && rise != 2'b00) begin
            if (rise[0] && m_s0 < 15) m_s0++;
            if (rise[1] && m_s1 < 15) m_s1++;
            m_last = rise[0] ? 0 : 1;
`ifdef SCORE_WIN_BY_TWO_EN
            if (m_s0 == 15 || m_s1 == 15) begin
                m_st = 3; m_win = (m_s0 >= m_s1) ? 0 : 1;
            end else if (m_s0 >= 7 && m_s0 >= m_s1 + 2) begin
                m_st = 3; m_win = 0;
            end else if (m_s1 >= 7 && m_s1 >= m_s0 + 2) begin
                m_st = 3; m_win = 1;
            end else begin
                m_st = 2; m_left = c_HOLD;
            end
`else
            if (m_s0 >= 7) begin
                m_st = 3; m_win = 0;
            end else if (m_s1 >= 7) begin
                m_st = 3; m_win = 1;
            end else begin
                m_st = 2; m_left = c_HOLD;
            end
`endif
        end else if (m_st == 2) begin
            m_left--;
            if (m_left == 0) m_st = 1;
        end
    endtask

    // Drive one clock of stimulus, queue the expectation, compare after the edge
    task automatic cyc(input logic r, input logic s, input logic [1:0] g);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        start = s;
        goal  = g;
        model_step(r, s, g);
        e.s0 = m_s0; e.s1 = m_s1; e.st = m_st; e.hold = (m_st == 2) ? 1 : 0;
        e.last = m_last; e.go = (m_st == 3) ? 1 : 0; e.win = m_win;
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        e = q_exp.pop_front();
        chk("score0", int'(score[3:0]), e.s0);
        chk("score1", int'(score[7:4]), e.s1);
        chk("state", int'(state), e.st);
        chk("serve_hold", int'(serve_hold), e.hold);
        chk("last_scorer", int'(last_scorer), e.last);
        chk("game_over", int'(game_over), e.go);
        if (e.go == 1) chk("winner", int'(winner), e.win);
        if (serve_hold) hold_seen++;
    endtask

    task automatic goal_and_hold(input logic [1:0] g);
        cyc(1'b1, 1'b0, g);
        repeat (c_HOLD + 1) cyc(1'b1, 1'b0, 2'b00);
    endtask

    initial begin
        n_vec = 0; n_err = 0; hold_seen = 0;
        rst_n = 1'b0; start = 1'b0; goal = 2'b00;
        m_goal_q = 2'b00;

        repeat (2) cyc(1'b0, 1'b0, 2'b00);
        chk("reset_state_idle", int'(state), 0);

        cyc(1'b1, 1'b1, 2'b00);
        chk("start_to_play", int'(state), 1);

        // One-clock goal, then a five-clock goal, hold expiring in between
        hold_seen = 0;
        cyc(1'b1, 1'b0, 2'b01);
        repeat (19) cyc(1'b1, 1'b0, 2'b00);
        chk("hold_len_first", hold_seen, 16);
        chk("score0_after_g1", int'(score[3:0]), 1);
        hold_seen = 0;
        repeat (5) cyc(1'b1, 1'b0, 2'b01);
        repeat (19) cyc(1'b1, 1'b0, 2'b00);
        chk("hold_len_second", hold_seen, 16);
        chk("score0_after_g2", int'(score[3:0]), 2);
        chk("score1_still_0", int'(score[7:4]), 0);

        // Goal raised during hold and held into play earns nothing
        cyc(1'b1, 1'b0, 2'b10);
        repeat (3) cyc(1'b1, 1'b0, 2'b00);
        repeat (25) cyc(1'b1, 1'b0, 2'b01);
        chk("held_goal_no_credit", int'(score[3:0]), 2);
        chk("held_goal_back_in_play", int'(state), 1);
        cyc(1'b1, 1'b0, 2'b00);
        goal_and_hold(2'b01);
        chk("fresh_rise_credit", int'(score[3:0]), 3);

        // 3-3 then a simultaneous goal
        goal_and_hold(2'b10);
        goal_and_hold(2'b10);
        goal_and_hold(2'b11);
        chk("tie_score0", int'(score[3:0]), 4);
        chk("tie_score1", int'(score[7:4]), 4);
        chk("tie_last_scorer", int'(last_scorer), 0);

        // Player 1 wins 7-5
        goal_and_hold(2'b01);
        goal_and_hold(2'b10);
        goal_and_hold(2'b10);
        goal_and_hold(2'b10);
        chk("win_game_over", int'(game_over), 1);
        chk("win_winner", int'(winner), 1);
        goal_and_hold(2'b01);
        goal_and_hold(2'b10);
        chk("over_frozen0", int'(score[3:0]), 5);
        chk("over_frozen1", int'(score[7:4]), 7);
        cyc(1'b1, 1'b1, 2'b00);
        chk("restart_state", int'(state), 1);
        chk("restart_score1", int'(score[7:4]), 0);

        // Start beats a goal in the same clock
        cyc(1'b1, 1'b1, 2'b01);
        chk("start_priority_score", int'(score[3:0]), 0);
        cyc(1'b1, 1'b0, 2'b00);

        // Reach 6-6, then player 0 scores twice
        for (int i = 0; i < 6; i++) begin
            goal_and_hold(2'b01);
            goal_and_hold(2'b10);
        end
        goal_and_hold(2'b01);
`ifdef SCORE_WIN_BY_TWO_EN
        chk("by_two_7_6_not_over", int'(game_over), 0);
        goal_and_hold(2'b01);
        chk("by_two_8_6_over", int'(game_over), 1);
        chk("by_two_winner", int'(winner), 0);
        chk("by_two_score0", int'(score[3:0]), 8);
`else
        chk("plain_7_6_over", int'(game_over), 1);
        chk("plain_winner", int'(winner), 0);
        goal_and_hold(2'b01);
        chk("plain_frozen", int'(score[3:0]), 7);
`endif

        // Reset in the middle of a hold at 2-1 with a goal held high
        cyc(1'b1, 1'b1, 2'b00);
        goal_and_hold(2'b01);
        goal_and_hold(2'b01);
        cyc(1'b1, 1'b0, 2'b10);
        cyc(1'b1, 1'b0, 2'b01);
        cyc(1'b1, 1'b0, 2'b01);
        cyc(1'b0, 1'b0, 2'b01);
        chk("mid_hold_reset_state", int'(state), 0);
        chk("mid_hold_reset_score0", int'(score[3:0]), 0);
        cyc(1'b1, 1'b1, 2'b01);
        repeat (3) cyc(1'b1, 1'b0, 2'b01);
        chk("post_reset_held_goal", int'(score[3:0]), 0);
        cyc(1'b1, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 2'b01);
        chk("post_reset_fresh_goal", int'(score[3:0]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
